logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

Parametrised, registered successor to the combinational basic-gate block. It computes one of eight bitwise gate functions on WIDTH-bit operands, with a valid/ready handshake and a one-deep output register. An optional chain mode feeds the previous result back as operand A, and a saturating counter records accepted operations. It sits between a stimulus/sequencer source and any consumer that can apply backpressure.

## Interface
Parameters:
- WIDTH, 8: operand and result width in bits; legal range 1 to 64.
- CNT_W, 16: width of the accepted-operation counter; legal range 4 to 32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  an operation is presented.
- in_ready  output  1  the block accepts the presented operation this cycle.
- in_op  input  3  function select; see Operation.
- in_chain  input  1  when 1, use last_result in place of in_a.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  out_data and the flags are valid.
- out_ready  input  1  the consumer takes the output this cycle.
- out_data  output  WIDTH  registered result.
- out_zero  output  1  out_data == 0.
- out_ones  output  1  out_data is all ones.
- out_parity  output  1  XOR-reduction of out_data.
- op_count  output  CNT_W  number of accepted operations, saturating.

## Operation
- Operand A is `opa = in_chain ? last_result : in_a`.
- in_op encoding (bitwise across all WIDTH bits):
  - 0: ~opa
  - 1: ~in_b
  - 2: opa | in_b
  - 3: opa & in_b
  - 4: opa ^ in_b
  - 5: ~(opa | in_b)
  - 6: ~(opa & in_b)
  - 7: ~(opa ^ in_b)
- All codes are legal; there is no error path.
- Accept condition: `accept = in_valid & in_ready`, with `in_ready = ~out_valid | out_ready`. This is a combinational path from out_ready to in_ready; it is permitted.
- On accept:
  - out_data is loaded with the result.
  - out_zero, out_ones and out_parity are loaded, computed from the new result (not from the old out_data).
  - out_valid is set to 1.
  - last_result is loaded with the result.
  - op_count increments by 1 and saturates at 2^CNT_W−1.
- Output hand-off without accept: if out_valid & out_ready and there is no accept, out_valid clears to 0. out_data, the flags and last_result keep their values.
- Simultaneous drain and accept (out_valid=1, out_ready=1, accept): the new result replaces the old one and out_valid stays 1. Full throughput is one operation per cycle.
- Stall: out_valid=1 and out_ready=0 gives in_ready=0. out_data and all flags hold stable until the output is taken.
- last_result changes only on accept. Chain mode therefore always uses the most recently accepted result, whether or not it has been consumed.
- No input is sampled while in_ready=0. in_a, in_b, in_op and in_chain are don't-care when in_valid=0.

## Timing
- Reset (async assert, applied immediately without waiting for clk):
  - out_valid=0
  - out_data=0
  - out_zero=1
  - out_ones=0
  - out_parity=0
  - op_count=0
  - last_result=0
- in_ready is 1 during and immediately after reset, because out_valid=0. While rst=1, no accept takes effect.
- Reset deassertion: logic samples from the first rising edge after rst falls. The system synchronises deassertion externally.
- Reset mid-operation: a pending output is discarded and the counter clears. There is no recovery of in-flight data.
- Latency: one cycle. An operation accepted at edge N is visible on out_data with out_valid=1 after edge N.
- The counter output is registered and updates on the same edge as out_data.
- Chain after reset uses last_result=0. For example, in_op=0 with in_chain=1 yields all ones.
- WIDTH=1 is legal: out_zero and out_ones are complementary, and out_parity equals out_data.

## Test plan
- Exhaustive ops, WIDTH=8: a=8'hA5, b=8'h3C, out_ready=1, in_op 0..7 on consecutive cycles. Required out_data sequence, one per cycle, with out_valid held at 1:
  - 5A, C3, BD, 24, 99, 42, DB, 66
- Backpressure: hold out_ready=0 after one accept (op=3, a=FF, b=0F).
  - out_data=0F and in_ready=0 hold for 5 cycles.
  - A second in_valid is not accepted and op_count stays 1.
  - Raise out_ready with the second op pending: both the drain and the accept occur on the same edge, and out_valid stays 1.
- Chain: accept op=4, a=F0, b=FF, giving 0F. Then accept op=2 with in_chain=1, b=30, giving 3F. Then op=0 with in_chain=1, giving C0.
  - Flags on the final result: out_zero=0, out_ones=0, out_parity=0.
- Flags: op=3, a=0, b=FF gives out_zero=1 and parity 0. op=5, a=0, b=0 gives out_ones=1 and parity 0. op=4, a=01, b=00 gives parity 1.
- Counter saturation with CNT_W=4: 20 back-to-back accepts leave op_count=15 and hold it there. Assert rst asynchronously between edges: op_count=0, out_valid=0 and out_zero=1 immediately, before the next edge.
- Mid-stream reset: with out_valid=1 and out_ready=0, pulse rst. After release, a chained op=0 yields all ones (last_result=0) and op_count=1.

Source files
------------

// File: rtl/logic_unit_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_pipe_if
//  Brief    : Operation/result handshake bundle for logic_unit_pipe.
//  Revision : 1.0  initial release
// ============================================================================
interface logic_unit_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic             in_chain;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;
   logic             out_ones;
   logic             out_parity;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, in_op, in_chain, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_ones, out_parity, op_count
   );

   modport slave (
      input  in_valid, in_op, in_chain, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_ones, out_parity, op_count
   );
endinterface
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_pipe
//  Brief    : Registered eight-function bitwise gate unit with valid/ready
//             handshake, optional result chaining and saturating op counter.
//  Revision : 1.0  initial release
// ============================================================================
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  wire logic         clk,
   input  wire logic         rst,
   logic_unit_pipe_if.slave  bus
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic             r_out_zero;
   logic             r_out_ones;
   logic             r_out_parity;
   logic [WIDTH-1:0] r_last_result;
   logic [CNT_W-1:0] r_op_count;

   logic             w_in_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_opa;
   logic [WIDTH-1:0] w_result;

   // The slot frees up in the same cycle the consumer drains it.
   assign w_in_ready = ~r_out_valid | bus.out_ready;
   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_opa      = bus.in_chain ? r_last_result : bus.in_a;

   always_comb begin
      w_result = '0;
      case (bus.in_op)
         3'd0:    w_result = ~w_opa;
         3'd1:    w_result = ~bus.in_b;
         3'd2:    w_result = w_opa | bus.in_b;
         3'd3:    w_result = w_opa & bus.in_b;
         3'd4:    w_result = w_opa ^ bus.in_b;
         3'd5:    w_result = ~(w_opa | bus.in_b);
         3'd6:    w_result = ~(w_opa & bus.in_b);
         default: w_result = ~(w_opa ^ bus.in_b);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_zero    <= 1'b1;
         r_out_ones    <= 1'b0;
         r_out_parity  <= 1'b0;
         r_last_result <= '0;
         r_op_count    <= '0;
      end else if (w_accept) begin
         // Flags come from the new result so they line up with out_data.
         r_out_valid   <= 1'b1;
         r_out_data    <= w_result;
         r_out_zero    <= (w_result == '0);
         r_out_ones    <= &w_result;
         r_out_parity  <= ^w_result;
         r_last_result <= w_result;
         if (r_op_count != c_cnt_max) begin
            r_op_count <= r_op_count + c_cnt_one;
         end
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_data   = r_out_data;
   assign bus.out_zero   = r_out_zero;
   assign bus.out_ones   = r_out_ones;
   assign bus.out_parity = r_out_parity;
   assign bus.op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_pipe
//  Brief    : Directed self-checking bench for logic_unit_pipe (WIDTH 8 and 1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_logic_unit_pipe;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   logic_unit_pipe_if #(.WIDTH(8), .CNT_W(4)) bus8 ();
   logic_unit_pipe_if #(.WIDTH(1), .CNT_W(4)) bus1 ();

   logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   logic_unit_pipe #(.WIDTH(1), .CNT_W(4)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive8(input logic v, input logic [2:0] op, input logic ch,
                         input logic [7:0] a, input logic [7:0] b);
      bus8.in_valid = v;
      bus8.in_op    = op;
      bus8.in_chain = ch;
      bus8.in_a     = a;
      bus8.in_b     = b;
   endtask

   task automatic pulse_rst();
      #2 rst = 1'b1;
      #1 rst = 1'b0;
   endtask

   logic [7:0] exp_ops [8];

   initial begin
      exp_ops = '{8'h5A, 8'hC3, 8'hBD, 8'h24, 8'h99, 8'h42, 8'hDB, 8'h66};
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      drive8(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
      bus8.out_ready = 1'b0;
      bus1.in_valid = 1'b0;  bus1.in_op = 3'd0;  bus1.in_chain = 1'b0;
      bus1.in_a = 1'b0;      bus1.in_b = 1'b0;   bus1.out_ready = 1'b0;
      #1;
      check("rst_valid",  64'(bus8.out_valid),  64'd0);
      check("rst_data",   64'(bus8.out_data),   64'h00);
      check("rst_zero",   64'(bus8.out_zero),   64'd1);
      check("rst_ones",   64'(bus8.out_ones),   64'd0);
      check("rst_parity", 64'(bus8.out_parity), 64'd0);
      check("rst_count",  64'(bus8.op_count),   64'd0);
      check("rst_ready",  64'(bus8.in_ready),   64'd1);
      // in_valid held during reset must not be accepted
      drive8(1'b1, 3'd1, 1'b0, 8'h00, 8'h00);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_noacc_valid", 64'(bus8.out_valid), 64'd0);
      check("rst_noacc_count", 64'(bus8.op_count),  64'd0);
      rst = 1'b0;

      // all eight functions back to back
      bus8.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive8(1'b1, 3'(i), 1'b0, 8'hA5, 8'h3C);
         tick();
         check($sformatf("op%0d_data", i), 64'(bus8.out_data), 64'(exp_ops[i]));
         check($sformatf("op%0d_valid", i), 64'(bus8.out_valid), 64'd1);
      end
      check("ops_count", 64'(bus8.op_count), 64'd8);
      bus8.in_valid = 1'b0;
      tick();
      check("drain_valid", 64'(bus8.out_valid), 64'd0);
      check("drain_hold",  64'(bus8.out_data),  64'h66);
      pulse_rst();
      check("rst2_count", 64'(bus8.op_count), 64'd0);

      // backpressure
      bus8.out_ready = 1'b0;
      drive8(1'b1, 3'd3, 1'b0, 8'hFF, 8'h0F);
      tick();
      drive8(1'b1, 3'd4, 1'b0, 8'hFF, 8'h0F);
      for (int i = 0; i < 5; i++) begin
         check("bp_data",  64'(bus8.out_data), 64'h0F);
         check("bp_ready", 64'(bus8.in_ready), 64'd0);
         tick();
      end
      check("bp_count", 64'(bus8.op_count), 64'd1);
      bus8.out_ready = 1'b1;
      #1;
      check("bp_ready_comb", 64'(bus8.in_ready), 64'd1);
      tick();
      check("bp_new_data",  64'(bus8.out_data),  64'hF0);
      check("bp_new_valid", 64'(bus8.out_valid), 64'd1);
      check("bp_new_count", 64'(bus8.op_count),  64'd2);

      // chain
      drive8(1'b1, 3'd4, 1'b0, 8'hF0, 8'hFF);
      tick();
      check("ch1_data", 64'(bus8.out_data), 64'h0F);
      drive8(1'b1, 3'd2, 1'b1, 8'hAA, 8'h30);
      tick();
      check("ch2_data", 64'(bus8.out_data), 64'h3F);
      drive8(1'b1, 3'd0, 1'b1, 8'hAA, 8'h00);
      tick();
      check("ch3_data",   64'(bus8.out_data),   64'hC0);
      check("ch3_zero",   64'(bus8.out_zero),   64'd0);
      check("ch3_ones",   64'(bus8.out_ones),   64'd0);
      check("ch3_parity", 64'(bus8.out_parity), 64'd0);

      // flags
      drive8(1'b1, 3'd3, 1'b0, 8'h00, 8'hFF);
      tick();
      check("fz_zero",   64'(bus8.out_zero),   64'd1);
      check("fz_parity", 64'(bus8.out_parity), 64'd0);
      drive8(1'b1, 3'd5, 1'b0, 8'h00, 8'h00);
      tick();
      check("fo_ones",   64'(bus8.out_ones),   64'd1);
      check("fo_parity", 64'(bus8.out_parity), 64'd0);
      check("fo_zero",   64'(bus8.out_zero),   64'd0);
      drive8(1'b1, 3'd4, 1'b0, 8'h01, 8'h00);
      tick();
      check("fp_parity", 64'(bus8.out_parity), 64'd1);
      check("fp_count",  64'(bus8.op_count),   64'd8);

      // counter saturation from a clean start
      bus8.in_valid = 1'b0;
      pulse_rst();
      for (int i = 0; i < 20; i++) begin
         drive8(1'b1, 3'd4, 1'b0, 8'(i), 8'h5A);
         tick();
         if (i == 14) check("sat_at15", 64'(bus8.op_count), 64'd15);
      end
      check("sat_count", 64'(bus8.op_count), 64'd15);
      check("sat_data",  64'(bus8.out_data), 64'(8'd19 ^ 8'h5A));
      bus8.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_count", 64'(bus8.op_count),  64'd0);
      check("async_valid", 64'(bus8.out_valid), 64'd0);
      check("async_zero",  64'(bus8.out_zero),  64'd1);
      rst = 1'b0;

      // mid-stream reset with a stalled output
      bus8.out_ready = 1'b0;
      drive8(1'b1, 3'd1, 1'b0, 8'h00, 8'h0F);
      tick();
      check("ms_valid", 64'(bus8.out_valid), 64'd1);
      bus8.in_valid = 1'b0;
      pulse_rst();
      check("ms_rst_valid", 64'(bus8.out_valid), 64'd0);
      bus8.out_ready = 1'b1;
      drive8(1'b1, 3'd0, 1'b1, 8'h55, 8'h00);
      tick();
      check("ms_chain_data", 64'(bus8.out_data),  64'hFF);
      check("ms_count",      64'(bus8.op_count),  64'd1);
      check("ms_out_valid",  64'(bus8.out_valid), 64'd1);
      bus8.in_valid = 1'b0;

      // single-bit instance
      bus1.out_ready = 1'b1;
      bus1.in_valid = 1'b1; bus1.in_op = 3'd5; bus1.in_a = 1'b0; bus1.in_b = 1'b0;
      tick();
      check("w1_data",   64'(bus1.out_data),   64'd1);
      check("w1_zero",   64'(bus1.out_zero),   64'd0);
      check("w1_ones",   64'(bus1.out_ones),   64'd1);
      check("w1_parity", 64'(bus1.out_parity), 64'd1);
      bus1.in_op = 3'd3; bus1.in_a = 1'b1; bus1.in_b = 1'b0;
      tick();
      check("w1b_data",   64'(bus1.out_data),   64'd0);
      check("w1b_zero",   64'(bus1.out_zero),   64'd1);
      check("w1b_ones",   64'(bus1.out_ones),   64'd0);
      check("w1b_parity", 64'(bus1.out_parity), 64'd0);
      bus1.in_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
